// File: rtl/onehot_dec_pkg.sv
// onehot_dec_pkg: shared types, mode constants and the binary-to-one-hot helper
// for the registered one-hot decoder.
package onehot_dec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest select the helper supports; callers size-cast the result down.
    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

    function automatic logic [MAX_OUT_W-1:0] bin2onehot(input logic [MAX_SEL_W-1:0] sel);
        return MAX_OUT_W'(1) << sel;
    endfunction

endpackage

// File: rtl/onehot_scan_div.sv
// onehot_scan_div: SCAN_DIV prescaler; emits a one-cycle step strobe every
// SCAN_DIV cycles while counting, and holds its counter at zero while i_clr is high.
module onehot_scan_div
    import onehot_dec_pkg::*;
#(
    parameter int SCAN_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_step
);

    localparam int CW = $clog2(SCAN_DIV + 1);

    logic [CW-1:0] r_cnt;

    assign o_step = ~i_clr & (r_cnt == CW'(SCAN_DIV - 1));

    // Count cycles, restarting on a step or whenever the scan is not running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= (i_clr | o_step) ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/onehot_decoder_seq.sv
// onehot_decoder_seq: registered binary-to-one-hot decoder with a handshaked
// DIRECT mode and a free-running walking-one SCAN mode.
// Optional self-check (sticky err output + assertion) enabled by ONEHOT_DEC_CHK_EN.
module onehot_decoder_seq
    import onehot_dec_pkg::*;
#(
    parameter  int SEL_W    = 4,
    parameter  int SCAN_DIV = 2,
    localparam int OUT_W    = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] sel,
    output logic             out_valid,
    output logic [OUT_W-1:0] onehot,
    output logic [SEL_W-1:0] idx,
    output logic             wrap
`ifdef ONEHOT_DEC_CHK_EN
    ,
    output logic             err
`endif
);

    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_W - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [OUT_W-1:0] w_onehot_nxt;
    logic [SEL_W-1:0] w_idx_nxt;
    logic             w_valid_nxt;
    logic             w_wrap_nxt;
    logic             w_run;
    logic             w_step;
    logic [SEL_W-1:0] w_idx_inc;
    logic [OUT_W-1:0] w_sel_dec;
    logic [OUT_W-1:0] w_inc_dec;

    assign w_run     = en & (mode == MODE_SCAN) & (r_state == SCAN);
    assign w_idx_inc = idx + SEL_W'(1);
    assign w_sel_dec = OUT_W'(bin2onehot(MAX_SEL_W'(sel)));
    assign w_inc_dec = OUT_W'(bin2onehot(MAX_SEL_W'(w_idx_inc)));
    assign in_ready  = rst_n & en & (mode == MODE_DIRECT) & (r_state != SCAN);

    onehot_scan_div #(
        .SCAN_DIV (SCAN_DIV)
    ) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (~w_run),
        .o_step (w_step)
    );

    // Next state and next registered outputs; en=0 beats mode change beats handshake/step.
    always_comb begin
        w_state_nxt  = r_state;
        w_onehot_nxt = onehot;
        w_idx_nxt    = idx;
        w_valid_nxt  = out_valid;
        w_wrap_nxt   = 1'b0;
        if (!en) begin
            w_state_nxt  = IDLE;
            w_onehot_nxt = '0;
            w_valid_nxt  = 1'b0;
        end else begin
            case (r_state)
                IDLE, HOLD: begin
                    if (mode == MODE_SCAN) begin
                        w_state_nxt  = SCAN;
                        w_onehot_nxt = OUT_W'(1);
                        w_idx_nxt    = '0;
                        w_valid_nxt  = 1'b1;
                    end else if (in_valid) begin
                        w_state_nxt  = HOLD;
                        w_onehot_nxt = w_sel_dec;
                        w_idx_nxt    = sel;
                        w_valid_nxt  = 1'b1;
                    end
                end
                SCAN: begin
                    if (mode == MODE_DIRECT) begin
                        w_state_nxt = HOLD;
                    end else if (w_step) begin
                        w_onehot_nxt = w_inc_dec;
                        w_idx_nxt    = w_idx_inc;
                        w_wrap_nxt   = (idx == IDX_LAST);
                    end
                end
                default: begin
                    w_state_nxt  = IDLE;
                    w_onehot_nxt = '0;
                    w_valid_nxt  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; async reset clears everything including wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            onehot    <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            onehot    <= w_onehot_nxt;
            idx       <= w_idx_nxt;
            out_valid <= w_valid_nxt;
            wrap      <= w_wrap_nxt;
        end
    end

`ifdef ONEHOT_DEC_CHK_EN
    logic w_bad;

    assign w_bad = out_valid ? ($countones(onehot) != 1) : (onehot != '0);

    // Sticky error flag, raised the cycle after the output breaks the one-hot rule.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (w_bad) begin
            err <= 1'b1;
        end
    end

    // Simulation-time check on the same condition.
    always @(posedge clk) begin
        if (rst_n) assert (!w_bad);
    end
`endif

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// tb_onehot_decoder_seq: directed plus random stimulus checked against a
// cycle-count based reference model of the decoder.
module tb_onehot_decoder_seq;

    localparam int SEL_W = 4;
    localparam int DIV   = 2;
    localparam int OUT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             mode = 1'b0;
    logic             in_valid = 1'b0;
    logic [SEL_W-1:0] sel = '0;
    logic             in_ready;
    logic             out_valid;
    logic [OUT_W-1:0] onehot;
    logic [SEL_W-1:0] idx;
    logic             wrap;
`ifdef ONEHOT_DEC_CHK_EN
    logic             err;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: scan position derived from cycles elapsed since scan entry.
    bit m_valid, m_scan, m_wrap;
    int m_idx, m_t;

    always #5 clk = ~clk;

    onehot_decoder_seq #(
        .SEL_W    (SEL_W),
        .SCAN_DIV (DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .onehot    (onehot),
        .idx       (idx),
        .wrap      (wrap)
`ifdef ONEHOT_DEC_CHK_EN
        ,
        .err       (err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_onehot();
        return m_valid ? (32'd1 << m_idx) : 32'd0;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_scan = 0; m_wrap = 0; m_idx = 0; m_t = 0;
    endtask

    task automatic model_step();
        if (!en) begin
            m_valid = 0; m_scan = 0; m_wrap = 0;
        end else if (mode) begin
            if (!m_scan) begin
                m_scan = 1; m_t = 0; m_idx = 0; m_valid = 1; m_wrap = 0;
            end else begin
                m_t++;
                m_idx  = (m_t / DIV) % OUT_W;
                m_wrap = (m_t % (DIV * OUT_W)) == 0;
            end
        end else begin
            m_wrap = 0;
            if (m_scan) m_scan = 0;
            else if (in_valid) begin
                m_idx = int'(sel); m_valid = 1;
            end
        end
    endtask

    task automatic check_outs();
        chk("onehot", onehot, m_onehot());
        chk("idx", idx, m_idx[SEL_W-1:0]);
        chk("out_valid", out_valid, m_valid);
        chk("wrap", wrap, m_wrap);
`ifdef ONEHOT_DEC_CHK_EN
        chk("err_quiet", err, 0);
`endif
    endtask

    task automatic cycle();
        #1;
        chk("in_ready", in_ready, en && !mode && !m_scan);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_wrap;
        model_reset();
        en = 1'b1;
        #2;
        chk("rst_onehot", onehot, 0);
        chk("rst_idx", idx, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;

        mode = 1'b0; in_valid = 1'b1; sel = 4'd3;
        cycle();
        chk("dir3", onehot, 16'h0008);
        in_valid = 1'b0;
        cycle();
        cycle();
        chk("dir3_held", onehot, 16'h0008);

        in_valid = 1'b1;
        sel = 4'd0;  cycle(); chk("b2b_0", onehot, 16'h0001);
        sel = 4'd15; cycle(); chk("b2b_15", onehot, 16'h8000);
        sel = 4'd9;  cycle(); chk("b2b_9", onehot, 16'h0200);
        in_valid = 1'b0;

        mode = 1'b1;
        in_valid = 1'b1;
        n_wrap = 0;
        for (int k = 0; k < 2 * DIV * OUT_W; k++) begin
            sel = 4'($urandom);
            cycle();
            n_wrap += int'(wrap);
        end
        chk("wrap_count", n_wrap, 1);
        in_valid = 1'b0;

        for (int k = 0; k < 200 && idx != 4'd7; k++) cycle();
        chk("scan_at7", idx, 7);
        mode = 1'b0;
        cycle();
        chk("hold7", onehot, 16'h0080);
        in_valid = 1'b1; sel = 4'd2;
        cycle();
        chk("hold_sel2", onehot, 16'h0004);
        in_valid = 1'b0;

        mode = 1'b1;
        cycle();
        for (int k = 0; k < 200 && idx != 4'd5; k++) cycle();
        en = 1'b0;
        cycle();
        chk("en0_onehot", onehot, 0);
        chk("en0_valid", out_valid, 0);
        chk("en0_idx", idx, 5);

        en = 1'b1; mode = 1'b1;
        repeat (9) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_onehot", onehot, 0);
        chk("arst_idx", idx, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_wrap", wrap, 0);
        mode = 1'b0;
        #1;
        chk("arst_ready", in_ready, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("arst_wrap_hold", wrap, 0);
        rst_n = 1'b1;

        for (int k = 0; k < 800; k++) begin
            en = ($urandom % 16) != 0;
            if ($urandom % 8 == 0) mode = ~mode;
            in_valid = 1'($urandom);
            sel = 4'($urandom);
            cycle();
        end

`ifdef ONEHOT_DEC_CHK_EN
        force dut.onehot = 16'h0003;
        @(posedge clk);
        @(negedge clk);
        chk("err_set", err, 1);
        release dut.onehot;
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk("err_sticky", err, 1);
        rst_n = 1'b0;
        #1;
        chk("err_rst", err, 0);
        rst_n = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
